// File: rtl/regfile_bypass_sb.sv
// Register file: two read ports, two write ports (wr1 wins on a tie),
// optional write-to-read bypass, optional hardwired r0, busy scoreboard.
module regfile_bypass_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              write_conflict
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DEPTH-1:0]  wr0_dec;
  logic [DEPTH-1:0]  wr1_dec;
  logic [DEPTH-1:0]  mark_dec;
  logic [DEPTH-1:0]  keep;
  logic              conflict_d;
  logic              same_addr;

  // Decode write and mark addresses into one-hot vectors; r0 may be masked.
  always_comb begin
    wr0_dec  = '0;
    wr1_dec  = '0;
    mark_dec = '0;
    keep     = '1;
    for (int i = 0; i < DEPTH; i++) begin
      wr0_dec[i]  = wr0_en  && (wr0_addr  == ADDR_W'(i));
      wr1_dec[i]  = wr1_en  && (wr1_addr  == ADDR_W'(i));
      mark_dec[i] = mark_en && (mark_addr == ADDR_W'(i));
    end
    if (ZR) keep[0] = 1'b0;
  end

  // Next busy state: writes retire a producer, a mark in the same edge wins.
  always_comb begin
    busy_d = ((busy_q & ~(wr0_dec | wr1_dec)) | mark_dec) & keep;
  end

  // Flag a same-address double write, except at a hardwired r0.
  always_comb begin
    same_addr  = wr0_en && wr1_en && (wr0_addr == wr1_addr);
    conflict_d = same_addr && !(ZR && (wr0_addr == '0));
  end

  // Register array update; wr1 has priority over wr0 at the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (keep[i]) begin
          if (wr1_dec[i]) regs[i] <= wr1_data;
          else if (wr0_dec[i]) regs[i] <= wr0_data;
        end
      end
    end
  end

  // Scoreboard and conflict pulse state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q         <= '0;
      write_conflict <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      write_conflict <= conflict_d;
    end
  end

  function automatic logic [DATA_W-1:0] rd(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = regs[a];
    if (BP && rst_n) begin
      if (wr1_en && (wr1_addr == a)) v = wr1_data;
      else if (wr0_en && (wr0_addr == a)) v = wr0_data;
    end
    if (ZR && (a == '0)) v = '0;
    return v;
  endfunction

  function automatic logic bz(
    input logic [ADDR_W-1:0] a
  );
    logic hit;
    hit = (wr0_en && (wr0_addr == a)) ||
          (wr1_en && (wr1_addr == a));
    return busy_q[a] && !(BP && hit);
  endfunction

  // Combinational read ports with optional bypass and busy masking.
  always_comb begin
    rs_data = rd(rs_addr);
    rt_data = rd(rt_addr);
    rs_busy = bz(rs_addr);
    rt_busy = bz(rt_addr);
  end

endmodule
